// File: rtl/kyber_pkg.sv
// Shared Kyber constants, loader state encoding and index helpers.
// Used by poly_ram_loader, ntt_lane_map and ntt_processor.
package kyber_pkg;
    localparam int KYBER_Q    = 3329;
    localparam int COEFF_W    = 12;
    localparam int KYBER_N    = 256;
    localparam int NTT_LANES  = 8;
    localparam int POLY_WORDS = KYBER_N / NTT_LANES;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_DONE
    } loader_state_t;

    function automatic logic [4:0] bitrev5(input logic [4:0] x);
        logic [4:0] r;
        for (int k = 0; k < 5; k++) begin
            r[k] = x[4 - k];
        end
        return r;
    endfunction
endpackage

// File: rtl/ntt_lane_map.sv
// Natural coefficient index -> {RAM word, lane} of the NTT memory layout.
// Purely combinational; no latency, no flow control.
module ntt_lane_map
    import kyber_pkg::*;
(
    input  logic [7:0] idx,
    output logic [4:0] word,
    output logic [2:0] lane
);
    assign word = bitrev5(idx[5:1]);
    assign lane = {idx[6], idx[7], idx[0]};
endmodule

// File: rtl/poly_ram_loader.sv
// Streams 256 coefficients in (reduced mod q, scattered into 32 lane-packed words), then writes 32 words to RAM.
// Flush starts the cycle after the last handshake; coeff_ready is high only while loading.
module poly_ram_loader #(
    parameter int Q       = kyber_pkg::KYBER_Q,
    parameter int COEFF_W = kyber_pkg::COEFF_W,
    parameter int N       = kyber_pkg::KYBER_N,
    parameter int LANES   = kyber_pkg::NTT_LANES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [7:0]                 w_data_addr_offset,
    input  logic [COEFF_W-1:0]         coeff_in,
    input  logic                       coeff_valid,
    output logic                       coeff_ready,
    output logic [LANES*COEFF_W-1:0]   w_data,
    output logic [7:0]                 w_data_addr,
    output logic                       w_data_en,
    output logic                       busy,
    output logic                       done
);
    import kyber_pkg::*;

    localparam int                 WORDS     = N / LANES;
    localparam int                 WORD_W    = LANES * COEFF_W;
    localparam logic [7:0]         LAST_IDX  = 8'(N - 1);
    localparam logic [4:0]         LAST_WORD = 5'(WORDS - 1);
    localparam logic [COEFF_W-1:0] Q_C       = COEFF_W'(Q);

    loader_state_t      state, state_next;
    logic [7:0]         idx;
    logic [7:0]         base;
    logic [4:0]         w;
    logic               hs;
    logic               last_hs;
    logic [COEFF_W-1:0] coeff_red;
    logic [4:0]         map_word;
    logic [2:0]         map_lane;
    logic [WORD_W-1:0]  word_buf [WORDS];

    assign coeff_ready = (state == ST_LOAD);
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);
    assign hs          = (state == ST_LOAD) && coeff_valid;
    assign last_hs     = hs && (idx == LAST_IDX);

    // Inputs never reach 2q, so a single conditional subtract fully reduces.
    assign coeff_red = (coeff_in >= Q_C) ? (coeff_in - Q_C) : coeff_in;

    ntt_lane_map u_lane_map (
        .idx  (idx),
        .word (map_word),
        .lane (map_lane)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_LOAD;
            ST_LOAD:  if (last_hs) state_next = ST_FLUSH;
            ST_FLUSH: if (w == LAST_WORD) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx  <= '0;
            base <= '0;
        end else begin
            if ((state == ST_IDLE) && start) begin
                idx  <= '0;
                base <= w_data_addr_offset;
            end else if (hs) begin
                idx <= idx + 8'd1;
            end
        end
    end

    // Buffer needs no reset: every lane is rewritten before the next flush.
    always_ff @(posedge clk) begin
        if (hs) begin
            word_buf[map_word][map_lane*COEFF_W +: COEFF_W] <= coeff_red;
        end
    end

    // Write port is registered one word ahead: the last handshake only
    // touches word 31, so word 0 is already final when it is fetched.
    always_ff @(posedge clk) begin
        if (rst) begin
            w           <= '0;
            w_data      <= '0;
            w_data_addr <= '0;
            w_data_en   <= 1'b0;
        end else if (last_hs) begin
            w           <= '0;
            w_data      <= word_buf[0];
            w_data_addr <= base;
            w_data_en   <= 1'b1;
        end else if ((state == ST_FLUSH) && (w != LAST_WORD)) begin
            w           <= w + 5'd1;
            w_data      <= word_buf[w + 5'd1];
            w_data_addr <= base + {3'b000, w} + 8'd1;
            w_data_en   <= 1'b1;
        end else begin
            w_data      <= '0;
            w_data_addr <= '0;
            w_data_en   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_poly_ram_loader.sv
// Scoreboard bench for poly_ram_loader: expected RAM writes are queued per load, a monitor pops and compares.
module tb_poly_ram_loader;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  w_data_addr_offset;
    logic [11:0] coeff_in;
    logic        coeff_valid;
    logic        coeff_ready;
    logic [95:0] w_data;
    logic [7:0]  w_data_addr;
    logic        w_data_en;
    logic        busy;
    logic        done;

    poly_ram_loader dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .w_data_addr_offset (w_data_addr_offset),
        .coeff_in           (coeff_in),
        .coeff_valid        (coeff_valid),
        .coeff_ready        (coeff_ready),
        .w_data             (w_data),
        .w_data_addr        (w_data_addr),
        .w_data_en          (w_data_en),
        .busy               (busy),
        .done               (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  addr;
        logic [95:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          coeffs[256];
    logic [95:0] captured[256];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          n_writes = 0;
    bit          mon_on = 0;
    bit          done_seen = 0;
    bit          wr_seen = 0;
    int          done_cyc = 0;
    int          wr_cyc = 0;

    localparam logic [95:0] RAMP_W0  = {12'd193, 12'd192, 12'd65, 12'd64, 12'd129, 12'd128, 12'd1, 12'd0};
    localparam logic [95:0] RAMP_W1  = {12'd225, 12'd224, 12'd97, 12'd96, 12'd161, 12'd160, 12'd33, 12'd32};
    localparam logic [95:0] RAMP_W31 = {12'd255, 12'd254, 12'd127, 12'd126, 12'd191, 12'd190, 12'd63, 12'd62};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [4:0] rev5(input int x);
        logic [4:0] v;
        logic [4:0] r;
        v = 5'(x);
        for (int j = 0; j < 5; j++) r[j] = v[4 - j];
        return r;
    endfunction

    function automatic logic [11:0] red(input int x);
        return (x >= 3329) ? 12'(x - 3329) : 12'(x);
    endfunction

    // Word w lanes 0..7 hold b, b+1, b+128, b+129, b+64, b+65, b+192, b+193.
    function automatic logic [95:0] exp_word(input int w);
        int          offs[8] = '{0, 1, 128, 129, 64, 65, 192, 193};
        int          b;
        logic [95:0] r;
        b = 2 * int'(rev5(w));
        r = '0;
        for (int l = 0; l < 8; l++) r[l*12 +: 12] = red(coeffs[b + offs[l]]);
        return r;
    endfunction

    always @(negedge clk) begin
        if (mon_on) begin
            if (w_data_en) begin
                if (!wr_seen) begin
                    wr_seen = 1;
                    wr_cyc  = cyc;
                end
                n_writes++;
                captured[w_data_addr] = w_data;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: got addr %0d data %0h, expected no write", w_data_addr, w_data);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("write_addr", {88'd0, w_data_addr}, {88'd0, e.addr});
                    check("write_data", w_data, e.data);
                end
            end else begin
                check("idle_wdata_zero", w_data, 96'd0);
                check("idle_waddr_zero", {88'd0, w_data_addr}, 96'd0);
            end
            if (done) begin
                done_seen = 1;
                done_cyc  = cyc;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_coeff_ready"}, {95'd0, coeff_ready}, 96'd0);
        check({tag, "_w_data"}, w_data, 96'd0);
        check({tag, "_w_data_addr"}, {88'd0, w_data_addr}, 96'd0);
        check({tag, "_w_data_en"}, {95'd0, w_data_en}, 96'd0);
        check({tag, "_busy"}, {95'd0, busy}, 96'd0);
        check({tag, "_done"}, {95'd0, done}, 96'd0);
    endtask

    task automatic run_load(input logic [7:0] off, input bit gaps, input bit poke, input int abort_at,
                            output int done_rel, output int wr_rel);
        int k;
        int c0;
        int guard;
        bit hs_now;
        wr_t e;
        done_rel = -1;
        wr_rel   = -1;
        if (abort_at < 0) begin
            for (int w = 0; w < 32; w++) begin
                e.addr = off + 8'(w);
                e.data = exp_word(w);
                exp_q.push_back(e);
            end
        end
        done_seen = 0;
        wr_seen   = 0;
        @(posedge clk); #1;
        start = 1'b1;
        w_data_addr_offset = off;
        c0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        w_data_addr_offset = 8'd77;
        k = 0;
        guard = 0;
        while (k < 256 && guard < 2000) begin
            coeff_in    = 12'(coeffs[k]);
            coeff_valid = gaps ? ((cyc - c0) % 2 == 0) : 1'b1;
            if (poke && k == 50) begin
                start = 1'b1;
                w_data_addr_offset = 8'd100;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (guard == 0) begin
                check("load_coeff_ready", {95'd0, coeff_ready}, 96'd1);
                check("load_busy", {95'd0, busy}, 96'd1);
            end
            hs_now = coeff_valid && coeff_ready;
            @(posedge clk); #1;
            guard++;
            if (hs_now) k++;
            if (abort_at >= 0 && k == abort_at) break;
        end
        coeff_valid = 1'b0;
        start = 1'b0;
        if (guard >= 2000) check("load_timeout", 96'(k), 96'd256);
        if (abort_at >= 0) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            check_all_zero("mid_load_reset");
            repeat (40) @(posedge clk);
            #1;
        end else begin
            if (poke) begin
                start = 1'b1;
                w_data_addr_offset = 8'd100;
                @(posedge clk); #1;
                start = 1'b0;
            end
            guard = 0;
            while (!done_seen && guard < 400) begin
                @(posedge clk); #1;
                guard++;
            end
            if (!done_seen) begin
                check("done_timeout", 96'd0, 96'd1);
            end else begin
                done_rel = done_cyc - c0;
                wr_rel   = wr_cyc - c0;
            end
            @(negedge clk);
            check("idle_after_done_busy", {95'd0, busy}, 96'd0);
            check("queue_drained", 96'(exp_q.size()), 96'd0);
        end
    endtask

    initial begin
        int dr;
        int wr;
        int wbase;
        logic [95:0] t;
        logic [11:0] lane_v;
        rst = 1'b1;
        start = 1'b0;
        w_data_addr_offset = '0;
        coeff_in = '0;
        coeff_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        mon_on = 1;

        // Ramp at offset 0
        for (int k = 0; k < 256; k++) coeffs[k] = k;
        wbase = n_writes;
        run_load(8'd0, 1'b0, 1'b0, -1, dr, wr);
        check("ramp_done_cycle", 96'(dr), 96'd289);
        check("ramp_first_write_cycle", 96'(wr), 96'd257);
        check("ramp_write_count", 96'(n_writes - wbase), 96'd32);
        t = captured[0];  check("ramp_addr0", t, RAMP_W0);
        t = captured[1];  check("ramp_addr1", t, RAMP_W1);
        t = captured[31]; check("ramp_addr31", t, RAMP_W31);

        // Reduction boundaries at offset 10
        coeffs[0] = 3328;
        coeffs[129] = 3329;
        coeffs[255] = 4095;
        run_load(8'd10, 1'b0, 1'b0, -1, dr, wr);
        t = captured[10]; lane_v = t[11:0];  check("red_3328", {84'd0, lane_v}, 96'd3328);
        t = captured[10]; lane_v = t[47:36]; check("red_3329", {84'd0, lane_v}, 96'd0);
        t = captured[41]; lane_v = t[95:84]; check("red_4095", {84'd0, lane_v}, 96'd766);

        // Backpressure: valid alternates, a gap before every handshake
        for (int k = 0; k < 256; k++) coeffs[k] = k;
        run_load(8'd0, 1'b1, 1'b0, -1, dr, wr);
        check("bp_done_cycle", 96'(dr), 96'd545);
        t = captured[1]; check("bp_addr1", t, RAMP_W1);

        // Address wrap
        wbase = n_writes;
        run_load(8'd240, 1'b0, 1'b0, -1, dr, wr);
        t = captured[240]; check("wrap_addr240", t, RAMP_W0);
        t = captured[15];  check("wrap_addr15", t, RAMP_W31);
        check("wrap_write_count", 96'(n_writes - wbase), 96'd32);

        // Start pulses while busy must be ignored
        wbase = n_writes;
        run_load(8'd5, 1'b0, 1'b1, -1, dr, wr);
        check("busy_start_write_count", 96'(n_writes - wbase), 96'd32);
        check("busy_start_done_cycle", 96'(dr), 96'd289);
        t = captured[5]; check("busy_start_addr5", t, RAMP_W0);

        // Reset after 100 handshakes, then a clean load
        wbase = n_writes;
        run_load(8'd0, 1'b0, 1'b0, 100, dr, wr);
        check("reset_no_writes", 96'(n_writes - wbase), 96'd0);
        for (int a = 0; a < 32; a++) captured[a] = '0;
        run_load(8'd0, 1'b0, 1'b0, -1, dr, wr);
        check("post_reset_done_cycle", 96'(dr), 96'd289);
        t = captured[0];  check("post_reset_addr0", t, RAMP_W0);
        t = captured[31]; check("post_reset_addr31", t, RAMP_W31);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/poly_ram_loader.md
# poly_ram_loader

Upstream feeder for `ntt_processor`. Accepts one 256-coefficient polynomial as a natural-order stream of 12-bit coefficients, for example from a sampler. It reduces each coefficient into [0, q) and permutes it into the 96-bit, 8-lane word layout that `ntt_processor` reads. It then writes the 32 packed words into the shared polynomial RAM starting at a caller-supplied offset. It drives the same RAM write-port signals as `ntt_processor` and never overlaps with it in time.

## Interface
Parameters:
- `Q`, 3329, Kyber modulus.
- `COEFF_W`, 12, coefficient width.
- `N`, 256, coefficients per polynomial.
- `LANES`, 8, coefficients per RAM word.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a load; sampled only in IDLE.
- `w_data_addr_offset`  in  8  base RAM word address; latched on accepted `start`.
- `coeff_in`  in  12  input coefficient, 0..4095.
- `coeff_valid`  in  1  `coeff_in` is valid.
- `coeff_ready`  out  1  loader accepts a coefficient this cycle.
- `w_data`  out  96  packed word; lane k occupies bits [12k+11:12k].
- `w_data_addr`  out  8  RAM write address.
- `w_data_en`  out  1  RAM write strobe.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the last word has been written.

## Operation
- FSM states: IDLE, LOAD, FLUSH, DONE.
  - IDLE -> LOAD on `start`; latch the offset and clear the coefficient counter `i` (8 bits).
  - LOAD: `coeff_ready`=1. Each cycle with `coeff_valid`&&`coeff_ready` is one handshake: store the reduced coefficient, then `i`++. The handshake with `i`=255 moves to FLUSH.
  - FLUSH: word counter `w` runs 0..31, one word per cycle. At `w`=31 move to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored. `start` is level-sampled, so holding it high in DONE re-triggers one cycle later, from IDLE.
- Reduction: if `coeff_in` >= Q, store `coeff_in`-Q, otherwise store `coeff_in`. One subtraction is sufficient because 4095 < 2Q.
- Lane mapping for coefficient i:
  - word w = bitrev5(i[5:1]).
  - lane = {i[6], i[7], i[0]}.
  - Result: word w holds, in lanes 0..7, coefficients b, b+1, b+128, b+129, b+64, b+65, b+192, b+193, where b = 2·bitrev5(w).
- Storage: a local 32×96 buffer, written per 12-bit lane; one lane written per handshake.
- FLUSH outputs:
  - `w_data` = buf[w].
  - `w_data_addr` = (offset + w) mod 256, so the address wraps at 8 bits.
  - `w_data_en`=1.
- Reset, including mid-LOAD or mid-FLUSH:
  - Next state is IDLE.
  - All outputs are 0: `coeff_ready`, `w_data`, `w_data_addr`, `w_data_en`, `busy`, `done`.
  - Buffer contents are don't-care; a fresh load overwrites every lane.

## Timing
- Cycle 0: `start` sampled in IDLE. Cycle 1: LOAD, `coeff_ready`=1.
- With `coeff_valid` held high, handshakes occur in cycles 1..256.
- FLUSH occupies cycles 257..288, writing addresses offset+0 .. offset+31.
- DONE (`done`=1) in cycle 289. IDLE in cycle 290.
- Gaps in `coeff_valid` extend LOAD one cycle per gap. FLUSH length is fixed at 32 cycles.
- All outputs are registered; `w_data`, `w_data_addr` and `w_data_en` change together.
- Outside FLUSH: `w_data_en`=0, `w_data`=0, `w_data_addr`=0.
- No input backpressure during FLUSH: `coeff_ready`=0 outside LOAD.

## Structure
- Shared package `kyber_pkg`:
  - Constants `KYBER_Q`, `COEFF_W`, `KYBER_N`, `NTT_LANES`, `POLY_WORDS`=32.
  - Function `bitrev5`.
  - State enum for this block.
  - `ntt_processor` reuses the same package.
- One natural sub-module: `ntt_lane_map`, purely combinational. It maps i -> {word, lane} and is reusable by a future unloader.

## Test plan
- Ramp: offset 0, `coeff_in` = i for i = 0..255, `coeff_valid` held high. Required words:
  - addr 0 = {193,192,65,64,129,128,1,0} (lane 7 .. lane 0).
  - addr 1 = {225,224,97,96,161,160,33,32}.
  - addr 31 = {255,254,127,126,191,190,63,62}.
  - `done` in cycle 289.
- Reduction: `coeff_in` 3328 -> 3328, 3329 -> 0, 4095 -> 766, each at its mapped lane.
- Backpressure: the ramp with `coeff_valid` toggling 1/0. Same 32 words as the ramp; `done` 256 cycles later than the ramp case.
- Wrap: offset 240 -> write addresses 240..255 then 0..15; data identical to the ramp.
- Start while busy: pulse `start` in LOAD and in FLUSH with offset 100. No effect; the original offset is kept and exactly 32 writes occur.
- Reset mid-LOAD, after 100 handshakes:
  - All outputs 0 in the next cycle and no writes occur.
  - A subsequent full ramp load produces exactly the ramp words.
